// File: rtl/c_fetch_resp_pkg.sv
// Shared types and defaults for the instruction-fetch responder.
// Holds the FSM state encoding, the buffered entry layout, and the default FIFO depth.
package c_fetch_resp_pkg;

   localparam int DEPTH_DEF    = 2;
   localparam int FETCH_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } type_fetch_state_e;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] addr;
      logic [31:0]             data;
   } type_fetch_entry_s;

endpackage

// File: rtl/c_fetch_resp_if.sv
// Bus between the C-extension realigner / instruction memory and the fetch responder.
// mem_req_o is a level request held until mem_ack_i; rsp_valid_o/rsp_ready_i transfer the head when both are high on an edge.
interface c_fetch_resp_if
   import c_fetch_resp_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic              req_i;
   logic              req_kill_i;
   logic              flush_i;
   logic [ADDR_W-1:0] addr_i;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_ack_i;
   logic [31:0]       mem_rdata_i;
   logic              rsp_valid_o;
   logic [31:0]       rsp_data_o;
   logic [ADDR_W-1:0] rsp_addr_o;
   logic              rsp_ready_i;
   logic              busy_o;
   type_fetch_state_e dbg_state;

   modport slave (
      input  req_i, req_kill_i, flush_i, addr_i, mem_ack_i, mem_rdata_i, rsp_ready_i,
      output mem_req_o, mem_addr_o, rsp_valid_o, rsp_data_o, rsp_addr_o, busy_o, dbg_state
   );

   modport master (
      output req_i, req_kill_i, flush_i, addr_i, mem_ack_i, mem_rdata_i, rsp_ready_i,
      input  mem_req_o, mem_addr_o, rsp_valid_o, rsp_data_o, rsp_addr_o, busy_o, dbg_state
   );
endinterface

// File: rtl/c_fetch_fifo.sv
// Small synchronous FIFO of {address, word} pairs with a same-edge clear.
// Head outputs read storage directly so the consumer sees the word without a register stage.
module c_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [AW-1:0] push_addr,
   input  logic [31:0]   push_data,
   output logic [CW-1:0] count,
   output logic [AW-1:0] head_addr,
   output logic [31:0]   head_data
);
   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Clear takes priority over any push or pop on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/c_fetch_resp.sv
// Fetch responder: issues word-aligned memory reads for the realigner and buffers returned words.
// A killed or flushed read keeps its request up until the ack, then its data is dropped.
module c_fetch_resp
   import c_fetch_resp_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = 32
) (
   input logic           clk,
   input logic           reset,
   c_fetch_resp_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   type_fetch_state_e state;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [CW-1:0]     count;
   logic              push;
   logic              pop;
   logic              cancel;

   assign cancel = bus.req_kill_i | bus.flush_i;
   assign push   = (state == REQ) && bus.mem_ack_i && !cancel;
   assign pop    = bus.rsp_valid_o && bus.rsp_ready_i;

   assign bus.mem_req_o   = mem_req;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.rsp_valid_o = (count != '0);
   assign bus.busy_o      = (state != IDLE);
   assign bus.dbg_state   = state;

   // Count cannot rise while a read is outstanding, so the entry check is enough to prevent overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_i && !cancel && (count < FULL)) begin
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= bus.addr_i & ~ADDR_W'(3);
               end
            end
            REQ: begin
               if (bus.mem_ack_i) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end else if (cancel) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.mem_ack_i) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   c_fetch_fifo #(
      .DEPTH (DEPTH),
      .AW    (ADDR_W),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .clear     (bus.flush_i),
      .push_addr (mem_addr),
      .push_data (bus.mem_rdata_i),
      .count     (count),
      .head_addr (bus.rsp_addr_o),
      .head_data (bus.rsp_data_o)
   );
endmodule

// File: tb/tb_c_fetch_resp.sv
// Directed bench for c_fetch_resp: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_c_fetch_resp;
   import c_fetch_resp_pkg::*;

   localparam int DEPTH = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   run      = 1'b0;

   c_fetch_resp_if #(.ADDR_W(32)) bus ();

   c_fetch_resp #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   type_fetch_entry_s exp_q[$];
   bit                m_busy = 1'b0;
   bit                m_keep = 1'b0;
   logic [31:0]       m_addr = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         m_busy = 1'b0;
         m_keep = 1'b0;
         m_addr = '0;
      end else begin
         bit pop_ok;
         bit push_ok;
         bit accept;
         bit cancel;
         cancel  = bus.req_kill_i || bus.flush_i;
         pop_ok  = (exp_q.size() != 0) && bus.rsp_ready_i;
         push_ok = m_busy && m_keep && bus.mem_ack_i && !cancel;
         accept  = !m_busy && bus.req_i && !cancel && (exp_q.size() < DEPTH);
         if (bus.flush_i) exp_q.delete();
         else begin
            if (pop_ok) void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back('{addr: m_addr, data: bus.mem_rdata_i});
         end
         if (m_busy) begin
            if (bus.mem_ack_i) m_busy = 1'b0;
            else if (cancel) m_keep = 1'b0;
         end else if (accept) begin
            m_busy = 1'b1;
            m_keep = 1'b1;
            m_addr = bus.addr_i & 32'hFFFF_FFFC;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run && reset === 1'b1) begin
         type_fetch_state_e exp_state;
         exp_state = !m_busy ? IDLE : (m_keep ? REQ : DRAIN);
         chk("mdl_mem_req", 64'(bus.mem_req_o), 64'(m_busy));
         chk("mdl_busy", 64'(bus.busy_o), 64'(m_busy));
         chk("mdl_state", 64'(bus.dbg_state), 64'(exp_state));
         if (m_busy) chk("mdl_mem_addr", 64'(bus.mem_addr_o), 64'(m_addr));
         chk("mdl_rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0)
            chk("mdl_rsp_head", {bus.rsp_addr_o, bus.rsp_data_o}, exp_q[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] d);
      bus.req_i  = 1'b1;
      bus.addr_i = a;
      tick();
      bus.req_i       = 1'b0;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = d;
      tick();
      bus.mem_ack_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, 64'(bus.mem_req_o), 64'd0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
      chk({tag, "_rsp_data"}, 64'(bus.rsp_data_o), 64'd0);
      chk({tag, "_rsp_addr"}, 64'(bus.rsp_addr_o), 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.req_i       = 1'b0;
      bus.req_kill_i  = 1'b0;
      bus.flush_i     = 1'b0;
      bus.addr_i      = '0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      bus.rsp_ready_i = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      run   = 1'b1;
      chk_all_zero("reset");

      // ack while idle is ignored
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hAAAA_5555;
      tick();
      bus.mem_ack_i = 1'b0;
      chk("idle_ack_ignored", 64'(bus.rsp_valid_o), 64'd0);

      // single fetch
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_1006;
      tick();
      bus.req_i = 1'b0;
      chk("single_mem_req", 64'(bus.mem_req_o), 64'd1);
      chk("single_mem_addr", 64'(bus.mem_addr_o), 64'h1004);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      bus.mem_ack_i = 1'b0;
      chk("single_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("single_data", 64'(bus.rsp_data_o), 64'hDEAD_BEEF);
      chk("single_addr", 64'(bus.rsp_addr_o), 64'h1004);
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      chk("single_popped", 64'(bus.rsp_valid_o), 64'd0);

      // FIFO full: third request waits for a pop
      fetch(32'h0000_2001, 32'h1111_0001);
      fetch(32'h0000_2007, 32'h1111_0002);
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_3000;
      tick();
      tick();
      chk("full_no_req", 64'(bus.mem_req_o), 64'd0);
      chk("full_head_addr", 64'(bus.rsp_addr_o), 64'h2000);
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      chk("full_after_pop_head", 64'(bus.rsp_addr_o), 64'h2004);
      tick();
      bus.req_i = 1'b0;
      chk("full_third_req", 64'(bus.mem_req_o), 64'd1);
      chk("full_third_addr", 64'(bus.mem_addr_o), 64'h3000);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h1111_0003;
      tick();
      bus.mem_ack_i   = 1'b0;
      bus.rsp_ready_i = 1'b1;
      repeat (3) tick();
      bus.rsp_ready_i = 1'b0;
      chk("full_drained", 64'(bus.rsp_valid_o), 64'd0);

      // kill mid-transaction, ack three cycles later
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_4008;
      tick();
      bus.req_i      = 1'b0;
      bus.req_kill_i = 1'b1;
      tick();
      bus.req_kill_i = 1'b0;
      tick();
      chk("kill_req_held", 64'(bus.mem_req_o), 64'd1);
      chk("kill_state", 64'(bus.dbg_state), 64'(DRAIN));
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hBAD0_0001;
      tick();
      bus.mem_ack_i = 1'b0;
      chk("kill_no_data", 64'(bus.rsp_valid_o), 64'd0);
      chk("kill_not_busy", 64'(bus.busy_o), 64'd0);
      chk("kill_req_low", 64'(bus.mem_req_o), 64'd0);

      // flush with a buffered entry and a read outstanding
      fetch(32'h0000_5000, 32'h2222_0001);
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_5004;
      tick();
      bus.req_i   = 1'b0;
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("flush_empty", 64'(bus.rsp_valid_o), 64'd0);
      chk("flush_draining", 64'(bus.busy_o), 64'd1);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hBAD0_0002;
      tick();
      bus.mem_ack_i = 1'b0;
      chk("flush_dropped", 64'(bus.rsp_valid_o), 64'd0);
      chk("flush_idle", 64'(bus.busy_o), 64'd0);

      // flush with two idle entries, simultaneous with a pop
      fetch(32'h0000_6000, 32'h3333_0001);
      fetch(32'h0000_6004, 32'h3333_0002);
      bus.flush_i     = 1'b1;
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.flush_i     = 1'b0;
      bus.rsp_ready_i = 1'b0;
      chk("flush2_empty", 64'(bus.rsp_valid_o), 64'd0);

      // ack and kill in the same cycle
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_7000;
      tick();
      bus.req_i       = 1'b0;
      bus.mem_ack_i   = 1'b1;
      bus.req_kill_i  = 1'b1;
      bus.mem_rdata_i = 32'hBAD0_0003;
      tick();
      bus.mem_ack_i  = 1'b0;
      bus.req_kill_i = 1'b0;
      chk("ackkill_no_push", 64'(bus.rsp_valid_o), 64'd0);
      chk("ackkill_idle", 64'(bus.dbg_state), 64'(IDLE));

      // reset mid-transaction, late ack ignored
      fetch(32'h0000_8000, 32'h4444_0001);
      bus.req_i  = 1'b1;
      bus.addr_i = 32'h0000_8004;
      tick();
      bus.req_i = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick();
      reset           = 1'b1;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h1234_5678;
      tick();
      bus.mem_ack_i = 1'b0;
      chk("late_ack_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("late_ack_busy", 64'(bus.busy_o), 64'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
